// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared constants and FSM encoding for the fetch PC redirect unit
package pc_redirect_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0010;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/pc_redirect_unit_target_align.sv
// pc_target_align: picks the redirect target, diverting misaligned targets to the trap vector
module pc_target_align
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic [31:0] b_pc_i,
  output logic [31:0] tgt_o,
  output logic        misalign_o
);
  assign misalign_o = |b_pc_i[1:0];
  assign tgt_o      = misalign_o ? TRAP_VEC : (b_pc_i & ALIGN_MASK);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC owner applying branch/jump redirects, deferring them while imem is busy
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_sel_i,
  input  logic [31:0]      b_pc_i,
  input  logic             stall_i,
  input  logic             imem_busy_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             imem_read_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             misalign_exc_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);
  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d, pend_q, pend_d, tgt;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               mis_q, mis_d, tgt_mis;

  pc_target_align #(.TRAP_VEC(TRAP_VEC)) u_align (
    .b_pc_i    (b_pc_i),
    .tgt_o     (tgt),
    .misalign_o(tgt_mis)
  );

  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state: redirect beats stall; a redirect during a busy fetch parks in pend_q until imem frees up
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    if (state_q == ST_WAIT) begin
      if (branch_sel_i) begin
        pend_d = tgt;
        mis_d  = tgt_mis;
      end
      if (!imem_busy_i) begin
        pc_d    = pend_d;
        cnt_d   = cnt_inc;
        state_d = ST_RUN;
      end
    end else if (branch_sel_i) begin
      mis_d = tgt_mis;
      if (imem_busy_i) begin
        pend_d  = tgt;
        state_d = ST_WAIT;
      end else begin
        pc_d  = tgt;
        cnt_d = cnt_inc;
      end
    end else if (!stall_i && !imem_busy_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // State, PC, pending target, counter and misalign pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_q + 32'd4;
  assign imem_read_o    = rst_n;
  assign flush_idex_o   = rst_n & branch_sel_i;
  assign flush_ifid_o   = rst_n & (branch_sel_i | (state_q == ST_WAIT));
  assign misalign_exc_o = mis_q;
  assign redirect_cnt_o = cnt_q;
endmodule
